// File: rtl/qos_pkg.sv
// Shared types and defaults for the QoS request dispatcher.
package qos_pkg;

  localparam int QOS_C_DEF     = 4;
  localparam int QOS_LEN_W_DEF = 12;
  localparam int QOS_TAG_W_DEF = 8;

  // Dispatcher FSM: waiting for a grant, or streaming beats of one descriptor.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } disp_state_e;

  // One queued request descriptor at the default widths.
  typedef struct packed {
    logic [QOS_LEN_W_DEF-1:0] len;
    logic [QOS_TAG_W_DEF-1:0] tag;
  } qos_desc_t;

  // True when exactly one bit of v is set.
  function automatic logic onehot32(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/qos_class_fifo.sv
// Per-class descriptor FIFO. Head is presented combinationally from storage;
// head_len reads as zero when the FIFO is empty.
module qos_class_fifo
  import qos_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LEN_W = QOS_LEN_W_DEF,
  parameter int TAG_W = QOS_TAG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [LEN_W-1:0] wr_len,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             rd_en,
  output logic [LEN_W-1:0] head_len,
  output logic [TAG_W-1:0] head_tag,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [LEN_W-1:0] len_mem_r [DEPTH];
  logic [TAG_W-1:0] tag_mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             wr_ok_s;
  logic             rd_ok_s;

  assign empty   = (count_r == {(AW+1){1'b0}});
  assign full    = (count_r == FULL_CNT);
  assign wr_ok_s = wr_en & ~full;
  assign rd_ok_s = rd_en & ~empty;

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      len_mem_r[wr_ptr_r] <= wr_len;
      tag_mem_r[wr_ptr_r] <= wr_tag;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head view; an empty FIFO advertises a zero length to the arbiter.
  always_comb begin
    head_len = {LEN_W{1'b0}};
    head_tag = {TAG_W{1'b0}};
    if (empty) begin
      head_len = {LEN_W{1'b0}};
      head_tag = {TAG_W{1'b0}};
    end else begin
      head_len = len_mem_r[rd_ptr_r];
      head_tag = tag_mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/qos_req_dispatch.sv
// QoS request dispatcher: per-class descriptor FIFOs feed an external DRR
// arbiter; a granted descriptor is expanded into a beat stream downstream.
module qos_req_dispatch
  import qos_pkg::*;
#(
  parameter int C     = QOS_C_DEF,
  parameter int LEN_W = QOS_LEN_W_DEF,
  parameter int TAG_W = QOS_TAG_W_DEF,
  parameter int DEPTH = 8,
  localparam int CLS_W = (C > 1) ? $clog2(C) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [C-1:0]       enq_valid,
  output logic [C-1:0]       enq_ready,
  input  logic [C*LEN_W-1:0] enq_len_flat,
  input  logic [C*TAG_W-1:0] enq_tag_flat,
  output logic [C-1:0]       req_valid,
  output logic [C*LEN_W-1:0] req_len_flat,
  input  logic [C-1:0]       grant,
  input  logic               grant_valid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLS_W-1:0]   out_class,
  output logic [TAG_W-1:0]   out_tag,
  output logic [LEN_W-1:0]   out_beat,
  output logic               out_last,
  output logic               drop_pulse,
  output logic               proto_err
);

  disp_state_e      state_r;
  logic [C-1:0]     fifo_empty_s;
  logic [C-1:0]     fifo_full_s;
  logic [C-1:0]     wr_en_s;
  logic [C-1:0]     rd_en_s;
  logic [C-1:0]     drop_hit_s;
  logic [LEN_W-1:0] head_len_s [C];
  logic [TAG_W-1:0] head_tag_s [C];

  logic [CLS_W-1:0] grant_idx_s;
  logic [LEN_W-1:0] sel_len_s;
  logic [TAG_W-1:0] sel_tag_s;
  logic             legal_s;
  logic             illegal_s;
  logic [LEN_W-1:0] next_beat_s;
  logic             next_last_s;

  logic             out_valid_r;
  logic             out_last_r;
  logic [CLS_W-1:0] out_class_r;
  logic [TAG_W-1:0] out_tag_r;
  logic [LEN_W-1:0] out_beat_r;
  logic [LEN_W-1:0] burst_len_r;
  logic             drop_r;
  logic             proto_r;

  for (genvar g = 0; g < C; g++) begin : g_class
    logic len_zero_s;
    assign len_zero_s    = (enq_len_flat[g*LEN_W +: LEN_W] == {LEN_W{1'b0}});
    assign enq_ready[g]  = ~fifo_full_s[g];
    assign drop_hit_s[g] = enq_valid[g] & ~fifo_full_s[g] & len_zero_s;
    assign wr_en_s[g]    = enq_valid[g] & ~fifo_full_s[g] & ~len_zero_s;
    assign rd_en_s[g]    = legal_s & grant[g];
    assign req_len_flat[g*LEN_W +: LEN_W] = head_len_s[g];

    qos_class_fifo #(
      .DEPTH (DEPTH),
      .LEN_W (LEN_W),
      .TAG_W (TAG_W)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en_s[g]),
      .wr_len   (enq_len_flat[g*LEN_W +: LEN_W]),
      .wr_tag   (enq_tag_flat[g*TAG_W +: TAG_W]),
      .rd_en    (rd_en_s[g]),
      .head_len (head_len_s[g]),
      .head_tag (head_tag_s[g]),
      .empty    (fifo_empty_s[g]),
      .full     (fifo_full_s[g])
    );
  end

  // Arbiter only sees requests while no burst is in flight.
  assign req_valid = (state_r == ST_IDLE) ? ~fifo_empty_s : {C{1'b0}};

  // Decode the grant: target class, its head descriptor, and legality.
  always_comb begin
    grant_idx_s = {CLS_W{1'b0}};
    sel_len_s   = {LEN_W{1'b0}};
    sel_tag_s   = {TAG_W{1'b0}};
    for (int i = 0; i < C; i++) begin
      grant_idx_s = grant_idx_s | (grant[i] ? CLS_W'(i) : {CLS_W{1'b0}});
      sel_len_s   = sel_len_s | (grant[i] ? head_len_s[i] : {LEN_W{1'b0}});
      sel_tag_s   = sel_tag_s | (grant[i] ? head_tag_s[i] : {TAG_W{1'b0}});
    end
    legal_s   = grant_valid & onehot32(32'(grant)) &
                ~(|(grant & fifo_empty_s)) & (state_r == ST_IDLE);
    illegal_s = grant_valid & ~legal_s;
  end

  // Beat advance; out_last for the following beat is precomputed here.
  assign next_beat_s = out_beat_r + LEN_W'(1);
  assign next_last_s = (next_beat_s == (burst_len_r - LEN_W'(1)));

  // Dispatcher FSM with registered beat-stream and event outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_class_r <= {CLS_W{1'b0}};
      out_tag_r   <= {TAG_W{1'b0}};
      out_beat_r  <= {LEN_W{1'b0}};
      burst_len_r <= {LEN_W{1'b0}};
      drop_r      <= 1'b0;
      proto_r     <= 1'b0;
    end else begin
      drop_r  <= |drop_hit_s;
      proto_r <= illegal_s;
      case (state_r)
        ST_IDLE: begin
          if (legal_s) begin
            state_r     <= ST_BURST;
            out_valid_r <= 1'b1;
            out_class_r <= grant_idx_s;
            out_tag_r   <= sel_tag_s;
            out_beat_r  <= {LEN_W{1'b0}};
            burst_len_r <= sel_len_s;
            out_last_r  <= (sel_len_s == LEN_W'(1));
          end else begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
          end
        end
        ST_BURST: begin
          if (out_ready) begin
            if (out_last_r) begin
              state_r     <= ST_IDLE;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
            end else begin
              out_beat_r <= next_beat_s;
              out_last_r <= next_last_s;
            end
          end else begin
            out_beat_r <= out_beat_r;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_r;
  assign out_last   = out_last_r;
  assign out_class  = out_class_r;
  assign out_tag    = out_tag_r;
  assign out_beat   = out_beat_r;
  assign drop_pulse = drop_r;
  assign proto_err  = proto_r;

endmodule
